mem_port_arbiter: RTL and testbench

//  Shares the single-ported memory bus between instruction fetch (IF) and the load/store

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter.
// Carries the instruction-fetch request/response, the load/store request/response
// and the single-ported memory bus.
//   slave  : arbiter view (requests and mem_ack/mem_rdata in, ready/rdata/mem_* out)
//   master : environment view (requesters plus memory), the mirror of slave
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_err;
  logic [31:0] d_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_ready, if_rdata, d_ready, d_err, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_err, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and the load/store
// path. One access at a time; data wins over fetch unless fetch has waited through
// STARVE_LIMIT consecutive data grants. Misaligned data accesses are rejected with
// d_err without touching the bus. All outputs are registered.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - mem_port_arbiter_if.slave (fetch, load/store and memory bus signals)
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a request; arbitration happens here
// GRANT_IF | bus cycle for fetch, waiting for mem_ack
// GRANT_D  | bus cycle for load/store, waiting for mem_ack
// RESP     | one-cycle ready pulse to the owner, requests ignored
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_D, RESP} state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_starve, w_starve;
  logic          r_mem_req, w_mem_req;
  logic          r_mem_we, w_mem_we;
  logic [31:0]   r_mem_addr, w_mem_addr;
  logic [31:0]   r_mem_wdata, w_mem_wdata;
  logic [3:0]    r_mem_wstrb, w_mem_wstrb;
  logic          r_if_ready, w_if_ready;
  logic [31:0]   r_if_rdata, w_if_rdata;
  logic          r_d_ready, w_d_ready;
  logic          r_d_err, w_d_err;
  logic [31:0]   r_d_rdata, w_d_rdata;

  logic          w_misaligned;
  logic [3:0]    w_d_strb;
  logic [31:0]   w_d_lanes;
  logic          w_pick_if;

  // Alignment check, strobes and lane replication for the data request.
  always_comb begin
    w_misaligned = 1'b1;
    w_d_strb     = 4'b0000;
    w_d_lanes    = bus.d_wdata;
    unique case (bus.d_size)
      2'd0: begin
        w_misaligned = 1'b0;
        w_d_strb     = 4'b0001 << bus.d_addr[1:0];
        w_d_lanes    = {4{bus.d_wdata[7:0]}};
      end
      2'd1: begin
        w_misaligned = bus.d_addr[0];
        w_d_strb     = 4'b0011 << {bus.d_addr[1], 1'b0};
        w_d_lanes    = {2{bus.d_wdata[15:0]}};
      end
      2'd2: begin
        w_misaligned = |bus.d_addr[1:0];
        w_d_strb     = 4'b1111;
      end
      default: w_misaligned = 1'b1;
    endcase
  end

  // Fetch wins if data is idle, or if fetch has already been passed over
  // STARVE_LIMIT times in a row.
  assign w_pick_if = bus.if_req && (!bus.d_req || (r_starve == STARVE_MAX));

  always_comb begin
    w_state     = r_state;
    w_starve    = r_starve;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_mem_wstrb = r_mem_wstrb;
    w_if_ready  = 1'b0;
    w_if_rdata  = r_if_rdata;
    w_d_ready   = 1'b0;
    w_d_err     = 1'b0;
    w_d_rdata   = r_d_rdata;

    unique case (r_state)
      IDLE: begin
        if (!bus.if_req) w_starve = '0;
        if (bus.d_req && w_misaligned) begin
          // Rejected without a bus cycle; not a grant, so the counter is untouched.
          w_state   = RESP;
          w_d_ready = 1'b1;
          w_d_err   = 1'b1;
        end else if (w_pick_if) begin
          w_state     = GRANT_IF;
          w_starve    = '0;
          w_mem_req   = 1'b1;
          w_mem_we    = 1'b0;
          w_mem_addr  = {bus.if_addr[31:2], 2'b00};
          w_mem_wdata = '0;
          w_mem_wstrb = 4'b0000;
        end else if (bus.d_req) begin
          w_state     = GRANT_D;
          w_mem_req   = 1'b1;
          w_mem_we    = bus.d_we;
          w_mem_addr  = {bus.d_addr[31:2], 2'b00};
          w_mem_wdata = bus.d_we ? w_d_lanes : 32'h0;
          w_mem_wstrb = bus.d_we ? w_d_strb : 4'b0000;
          if (bus.if_req && (r_starve != STARVE_MAX)) w_starve = r_starve + 1'b1;
        end
      end
      GRANT_IF: begin
        if (bus.mem_ack) begin
          w_state     = RESP;
          w_mem_req   = 1'b0;
          w_mem_we    = 1'b0;
          w_mem_wstrb = 4'b0000;
          w_if_ready  = 1'b1;
          w_if_rdata  = bus.mem_rdata;
        end
      end
      GRANT_D: begin
        if (bus.mem_ack) begin
          w_state     = RESP;
          w_mem_req   = 1'b0;
          w_mem_we    = 1'b0;
          w_mem_wstrb = 4'b0000;
          w_d_ready   = 1'b1;
          w_d_rdata   = bus.mem_rdata;
        end
      end
      RESP:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_starve    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_if_ready  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_ready   <= 1'b0;
      r_d_err     <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      r_state     <= w_state;
      r_starve    <= w_starve;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_wstrb <= w_mem_wstrb;
      r_if_ready  <= w_if_ready;
      r_if_rdata  <= w_if_rdata;
      r_d_ready   <= w_d_ready;
      r_d_err     <= w_d_err;
      r_d_rdata   <= w_d_rdata;
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.if_ready  = r_if_ready;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_ready   = r_d_ready;
  assign bus.d_err     = r_d_err;
  assign bus.d_rdata   = r_d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: reset state, a table of single accesses,
// hand-written multi-cycle sequences, and a randomized run against a transaction model.
module tb_mem_port_arbiter;
  localparam int LIMIT = 2;
  localparam int NC    = 1500;
  localparam int NA    = NC + 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  logic resp_en    = 1'b1;
  int   resp_delay = 1;
  logic late_ack   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'h0000_0113;
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
  endfunction

  function automatic logic tb_mis(input logic [1:0] size, input logic [31:0] a);
    int nb;
    nb = nbytes(size);
    return (nb == 0) || ((int'(a[1:0]) % nb) != 0);
  endfunction

  function automatic logic [3:0] tb_strb(input logic [1:0] size, input logic [31:0] a);
    int nb;
    nb = nbytes(size);
    return 4'(((1 << nb) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] tb_lanes(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    int nb;
    nb = nbytes(size);
    r = '0;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = wd[(i % nb)*8 +: 8];
    return r;
  endfunction

  // Memory responder: acks resp_delay cycles after mem_req first appears.
  initial begin
    int   wait_cnt;
    logic acked;
    wait_cnt      = 0;
    acked         = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_ack = 1'b0;
      if (!bus.mem_req) begin
        acked    = 1'b0;
        wait_cnt = 0;
      end else if (resp_en && !acked) begin
        if (wait_cnt >= resp_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rd_of(bus.mem_addr);
          acked         = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
      if (late_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    int    waited;
    logic  rdy;
    tag = $sformatf("vec%0d", idx);
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_size = v.size;
      bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end
    step();
    if (v.exp_err) begin
      chk({tag, " mem_req"}, 32'(bus.mem_req), 0);
      chk({tag, " d_ready"}, 32'(bus.d_ready), 1);
      chk({tag, " d_err"}, 32'(bus.d_err), 1);
      bus.d_req = 1'b0;
      step();
      chk({tag, " d_ready clr"}, 32'(bus.d_ready), 0);
      chk({tag, " d_err clr"}, 32'(bus.d_err), 0);
    end else begin
      chk({tag, " mem_req"}, 32'(bus.mem_req), 1);
      chk({tag, " mem_addr"}, bus.mem_addr, v.exp_addr);
      chk({tag, " mem_we"}, 32'(bus.mem_we), 32'(v.is_d & v.we));
      chk({tag, " mem_wstrb"}, 32'(bus.mem_wstrb), 32'(v.exp_strb));
      if (v.is_d && v.we) chk({tag, " mem_wdata"}, bus.mem_wdata, v.exp_wdata);
      waited = 0;
      rdy = v.is_d ? bus.d_ready : bus.if_ready;
      while (!rdy && waited < 10) begin
        step();
        waited++;
        rdy = v.is_d ? bus.d_ready : bus.if_ready;
      end
      chk({tag, " ready latency"}, 32'(waited), 2);
      chk({tag, " rdata"}, v.is_d ? bus.d_rdata : bus.if_rdata, rd_of(v.exp_addr));
      if (v.is_d) chk({tag, " d_err"}, 32'(bus.d_err), 0);
      chk({tag, " mem_req in resp"}, 32'(bus.mem_req), 0);
      bus.d_req = 1'b0; bus.if_req = 1'b0;
      step();
      chk({tag, " ready pulse"}, 32'(v.is_d ? bus.d_ready : bus.if_ready), 0);
    end
  endtask

  // Randomized-phase expectation arrays, indexed by cycle.
  logic        e_req [NA];
  logic        e_ifr [NA];
  logic        e_dr  [NA];
  logic        e_de  [NA];
  logic        e_we  [NA];
  logic [3:0]  e_strb[NA];
  logic [31:0] e_addr[NA];
  logic [31:0] e_wd  [NA];
  logic [31:0] e_ifv [NA];
  logic [31:0] e_dv  [NA];

  initial begin
    vec_t vecs[10];
    int   ord[4];
    logic [31:0] seen[4];
    int   nord, nseen;
    logic prev;
    int   exp5[4];

    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_size = 0; bus.d_addr = 0; bus.d_wdata = 0;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst mem_req", 32'(bus.mem_req), 0);
    chk("rst mem_we", 32'(bus.mem_we), 0);
    chk("rst mem_wstrb", 32'(bus.mem_wstrb), 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst mem_wdata", bus.mem_wdata, 0);
    chk("rst if_ready", 32'(bus.if_ready), 0);
    chk("rst d_ready", 32'(bus.d_ready), 0);
    chk("rst d_err", 32'(bus.d_err), 0);
    chk("rst if_rdata", bus.if_rdata, 0);
    chk("rst d_rdata", bus.d_rdata, 0);
    rst = 1'b0;
    step();

    // Single-access table: is_d we size addr wdata | err addr strb wdata
    vecs[0] = '{1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 2'd0, 32'h0000_1003, 32'h0000_00AB, 1'b0, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB};
    vecs[2] = '{1'b1, 1'b1, 2'd2, 32'h0000_1002, 32'h1111_2222, 1'b1, 32'h0, 4'b0000, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 2'd1, 32'h0000_2002, 32'h1234_BEEF, 1'b0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF};
    vecs[4] = '{1'b1, 1'b1, 2'd1, 32'h0000_2001, 32'h1234_BEEF, 1'b1, 32'h0, 4'b0000, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 2'd2, 32'h0000_3004, 32'h0, 1'b0, 32'h0000_3004, 4'b0000, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 2'd3, 32'h0000_4000, 32'h5555_5555, 1'b1, 32'h0, 4'b0000, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 2'd0, 32'h0000_5001, 32'hFFFF_FF77, 1'b0, 32'h0000_5000, 4'b0010, 32'h7777_7777};
    vecs[8] = '{1'b1, 1'b1, 2'd2, 32'h0000_6008, 32'hCAFE_F00D, 1'b0, 32'h0000_6008, 4'b1111, 32'hCAFE_F00D};
    vecs[9] = '{1'b1, 1'b0, 2'd0, 32'h0000_7003, 32'h0, 1'b0, 32'h0000_7000, 4'b0000, 32'h0};
    resp_delay = 1;
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
    chk("if_rdata retained", bus.if_rdata, rd_of(32'h100));

    // Simultaneous fetch and load: data first
    bus.if_req = 1; bus.if_addr = 32'h200;
    bus.d_req = 1; bus.d_we = 0; bus.d_size = 2; bus.d_addr = 32'h2000;
    nord = 0; nseen = 0; prev = 1'b0;
    for (int c = 0; c < 20 && nord < 2; c++) begin
      step();
      if (bus.mem_req && !prev && nseen < 4) begin seen[nseen] = bus.mem_addr; nseen++; end
      prev = bus.mem_req;
      if (bus.d_ready && nord < 4) begin ord[nord] = 1; nord++; bus.d_req = 0; end
      if (bus.if_ready && nord < 4) begin ord[nord] = 0; nord++; bus.if_req = 0; end
    end
    chk("t2 ready count", 32'(nord), 2);
    chk("t2 bus count", 32'(nseen), 2);
    if (nseen == 2) begin
      chk("t2 first addr", seen[0], 32'h2000);
      chk("t2 second addr", seen[1], 32'h200);
    end
    if (nord == 2) begin
      chk("t2 first ready is d", 32'(ord[0]), 1);
      chk("t2 second ready is if", 32'(ord[1]), 0);
    end
    step();

    // Starvation guard: grant order D, D, IF, D
    rst = 1; step(); rst = 0;
    exp5[0] = 1; exp5[1] = 1; exp5[2] = 0; exp5[3] = 1;
    bus.if_req = 1; bus.if_addr = 32'h400;
    bus.d_req = 1; bus.d_we = 0; bus.d_size = 2; bus.d_addr = 32'h3000;
    nord = 0;
    for (int c = 0; c < 60 && nord < 4; c++) begin
      step();
      if (bus.d_ready && nord < 4) begin ord[nord] = 1; nord++; end
      if (bus.if_ready && nord < 4) begin ord[nord] = 0; nord++; end
    end
    bus.if_req = 0; bus.d_req = 0;
    chk("t5 grant count", 32'(nord), 4);
    for (int i = 0; i < nord; i++) chk($sformatf("t5 grant%0d", i), 32'(ord[i]), 32'(exp5[i]));
    repeat (3) step();

    // Reset while a data access waits for ack
    resp_en = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_size = 2; bus.d_addr = 32'h5004;
    step();
    chk("t6 mem_req granted", 32'(bus.mem_req), 1);
    step();
    rst = 1; bus.d_req = 0;
    step();
    rst = 0;
    chk("t6 mem_req after rst", 32'(bus.mem_req), 0);
    chk("t6 d_ready after rst", 32'(bus.d_ready), 0);
    late_ack = 1;
    step();
    late_ack = 0;
    chk("t6 d_ready late ack", 32'(bus.d_ready), 0);
    step();
    chk("t6 d_ready late ack+1", 32'(bus.d_ready), 0);
    chk("t6 d_rdata untouched", bus.d_rdata, 0);
    chk("t6 mem_req idle", 32'(bus.mem_req), 0);
    resp_en = 1;
    run_vec('{1'b0, 1'b0, 2'd2, 32'h0000_0500, 32'h0, 1'b0, 32'h0000_0500, 4'b0000, 32'h0}, 100);

    // Randomized run against a transaction-level model
    begin
      int   free, starve, if_done, d_done, dly, r;
      logic if_act, d_act, d_we_v;
      logic [1:0]  d_size_v;
      logic [31:0] if_addr_v, d_addr_v, d_wd_v, wa, m_if_rd, m_d_rd;
      for (int i = 0; i < NA; i++) begin
        e_req[i] = 0; e_ifr[i] = 0; e_dr[i] = 0; e_de[i] = 0; e_we[i] = 0;
        e_strb[i] = 0; e_addr[i] = 0; e_wd[i] = 0; e_ifv[i] = 0; e_dv[i] = 0;
      end
      free = 0; starve = 0; if_done = NA; d_done = NA;
      if_act = 0; d_act = 0; d_we_v = 0; d_size_v = 0;
      if_addr_v = 0; d_addr_v = 0; d_wd_v = 0; m_if_rd = 0; m_d_rd = 0;
      bus.if_req = 0; bus.d_req = 0;
      rst = 1; step(); rst = 0;
      for (int k = 0; k < NC; k++) begin
        if (e_ifr[k]) m_if_rd = e_ifv[k];
        if (e_dr[k] && !e_de[k]) m_d_rd = e_dv[k];
        chk($sformatf("rnd c%0d mem_req", k), 32'(bus.mem_req), 32'(e_req[k]));
        chk($sformatf("rnd c%0d if_ready", k), 32'(bus.if_ready), 32'(e_ifr[k]));
        chk($sformatf("rnd c%0d d_ready", k), 32'(bus.d_ready), 32'(e_dr[k]));
        chk($sformatf("rnd c%0d d_err", k), 32'(bus.d_err), 32'(e_de[k]));
        chk($sformatf("rnd c%0d if_rdata", k), bus.if_rdata, m_if_rd);
        chk($sformatf("rnd c%0d d_rdata", k), bus.d_rdata, m_d_rd);
        if (e_req[k]) begin
          chk($sformatf("rnd c%0d mem_addr", k), bus.mem_addr, e_addr[k]);
          chk($sformatf("rnd c%0d mem_we", k), 32'(bus.mem_we), 32'(e_we[k]));
          chk($sformatf("rnd c%0d mem_wstrb", k), 32'(bus.mem_wstrb), 32'(e_strb[k]));
          if (e_we[k]) chk($sformatf("rnd c%0d mem_wdata", k), bus.mem_wdata, e_wd[k]);
        end

        if (if_act && if_done < k) if_act = 0;
        if (d_act && d_done < k) d_act = 0;
        if (!if_act && $urandom_range(0, 2) == 0) begin
          if_act = 1; if_done = NA; if_addr_v = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_act && $urandom_range(0, 2) == 0) begin
          d_act = 1; d_done = NA;
          d_we_v = 1'($urandom_range(0, 1));
          d_size_v = 2'($urandom_range(0, 3));
          d_addr_v = $urandom;
          if ($urandom_range(0, 1) == 1) d_addr_v[1:0] = 2'b00;
          d_wd_v = $urandom;
        end
        bus.if_req = if_act; bus.if_addr = if_addr_v;
        bus.d_req = d_act; bus.d_we = d_we_v; bus.d_size = d_size_v;
        bus.d_addr = d_addr_v; bus.d_wdata = d_wd_v;

        if (k >= free) begin
          if (!if_act) starve = 0;
          if (d_act && tb_mis(d_size_v, d_addr_v)) begin
            e_dr[k+1] = 1; e_de[k+1] = 1; d_done = k + 1; free = k + 2;
          end else if (if_act && (!d_act || starve == LIMIT)) begin
            dly = $urandom_range(0, 3); resp_delay = dly;
            wa = if_addr_v & 32'hFFFF_FFFC;
            for (int t = k + 1; t <= k + 1 + dly; t++) begin
              e_req[t] = 1; e_addr[t] = wa; e_we[t] = 0; e_strb[t] = 0;
            end
            r = k + 2 + dly;
            e_ifr[r] = 1; e_ifv[r] = rd_of(wa); if_done = r; free = r + 1;
            starve = 0;
          end else if (d_act) begin
            dly = $urandom_range(0, 3); resp_delay = dly;
            wa = d_addr_v & 32'hFFFF_FFFC;
            for (int t = k + 1; t <= k + 1 + dly; t++) begin
              e_req[t] = 1; e_addr[t] = wa; e_we[t] = d_we_v;
              e_strb[t] = d_we_v ? tb_strb(d_size_v, d_addr_v) : 4'b0000;
              e_wd[t] = tb_lanes(d_size_v, d_wd_v);
            end
            r = k + 2 + dly;
            e_dr[r] = 1; e_dv[r] = rd_of(wa); d_done = r; free = r + 1;
            if (if_act) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
          end
        end
        step();
      end
      bus.if_req = 0; bus.d_req = 0;
      repeat (8) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
